// File: rtl/uart_tx_pkg.sv
// Shared FSM state type and line-level constants for the UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity generator for the UART transmitter: even parity is the XOR of the data,
// odd parity is its inverse.
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_parTyp,
  output logic                  o_parity
);

  always_comb begin
    o_parity = (i_parTyp == PAR_ODD) ? ~(^i_data) : (^i_data);
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit core: start bit, DATA_WIDTH data bits LSB first, optional parity
// bit (macro UART_TX_PARITY_EN), stop bit. Outputs are registered from the next state.
module uart_tx_core
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
`ifdef UART_TX_PARITY_EN
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`endif
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_t             r_state;
  tx_state_t             w_nextState;
  logic [CNT_W-1:0]      r_bitCnt;
  logic [CNT_W-1:0]      w_nextBitCnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_txOut;
  logic                  r_busy;
  logic                  w_nextTx;
  logic                  w_nextBusy;
  logic                  w_accept;

`ifdef UART_TX_PARITY_EN
  logic r_parEn;
  logic r_parTyp;
  logic w_parityBit;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .i_data   (r_data),
    .i_parTyp (r_parTyp),
    .o_parity (w_parityBit)
  );
`endif

  // Only IDLE and STOP may accept, so a request held through STOP chains frames with no gap.
  always_comb begin
    w_accept     = DATA_VALID && ((r_state == IDLE) || (r_state == STOP));
    w_nextState  = r_state;
    w_nextBitCnt = r_bitCnt;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = START;
      START: begin
        w_nextState  = DATA;
        w_nextBitCnt = '0;
      end
      DATA: begin
        if (r_bitCnt == LAST_BIT) begin
          w_nextBitCnt = '0;
`ifdef UART_TX_PARITY_EN
          w_nextState  = r_parEn ? PARITY : STOP;
`else
          w_nextState  = STOP;
`endif
        end else begin
          w_nextBitCnt = r_bitCnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY:  w_nextState = STOP;
`endif
      STOP:    w_nextState = w_accept ? START : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The line level is decoded from the next state so TX_OUT and BUSY change with the state.
  always_comb begin
    w_nextTx   = IDLE_LEVEL;
    w_nextBusy = 1'b1;
    case (w_nextState)
      IDLE:    w_nextBusy = 1'b0;
      START:   w_nextTx   = START_BIT;
      DATA:    w_nextTx   = r_data[w_nextBitCnt];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_nextTx   = w_parityBit;
`endif
      STOP:    w_nextTx   = STOP_BIT;
      default: begin
        w_nextTx   = IDLE_LEVEL;
        w_nextBusy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state  <= IDLE;
      r_bitCnt <= '0;
      r_data   <= '0;
      r_txOut  <= IDLE_LEVEL;
      r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parEn  <= 1'b0;
      r_parTyp <= 1'b0;
`endif
    end else begin
      r_state  <= w_nextState;
      r_bitCnt <= w_nextBitCnt;
      r_txOut  <= w_nextTx;
      r_busy   <= w_nextBusy;
      if (w_accept) begin
        r_data   <= P_DATA;
`ifdef UART_TX_PARITY_EN
        r_parEn  <= PAR_EN;
        r_parTyp <= PAR_TYP;
`endif
      end
    end
  end

  assign TX_OUT = r_txOut;
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: accepted frames push their expected line bits,
// and every cycle pops one bit (or expects idle) and compares TX_OUT and BUSY.
module tb_uart_tx_core;

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_BUILT = 1'b1;
`else
  localparam bit PARITY_BUILT = 1'b0;
`endif

  logic       CLK;
  logic       rst;
  logic [7:0] pData;
  logic       dataValid;
  logic       parEn;
  logic       parTyp;
  logic       txOut;
  logic       busy;

  bit expQ[$];
  int vectors;
  int miscompares;

  uart_tx_core #(
    .DATA_WIDTH(8)
  ) dut (
    .CLK        (CLK),
    .RST        (rst),
    .P_DATA     (pData),
    .DATA_VALID (dataValid),
`ifdef UART_TX_PARITY_EN
    .PAR_EN     (parEn),
    .PAR_TYP    (parTyp),
`endif
    .TX_OUT     (txOut),
    .BUSY       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic actual, input logic expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected serial image: start, data LSB first, optional parity, stop.
  task automatic pushFrame(input logic [7:0] d, input logic pe, input logic pt);
    expQ.push_back(1'b0);
    for (int i = 0; i < 8; i++) expQ.push_back(d[i]);
    if (pe) expQ.push_back((^d) ^ pt);
    expQ.push_back(1'b1);
  endtask

  // The DUT sits in IDLE or STOP exactly when no expected bits remain queued.
  task automatic stepCycle(input string tag);
    logic       accept;
    logic       inReset;
    logic [7:0] capD;
    logic       capPe;
    logic       capPt;
    bit         expTx;
    bit         expBusy;
    accept  = dataValid && rst && (expQ.size() == 0);
    inReset = !rst;
    capD    = pData;
    capPe   = parEn & PARITY_BUILT;
    capPt   = parTyp;
    @(posedge CLK);
    #1;
    if (inReset) expQ.delete();
    else if (accept) pushFrame(capD, capPe, capPt);
    if (expQ.size() > 0) begin
      expTx   = expQ.pop_front();
      expBusy = 1'b1;
    end else begin
      expTx   = 1'b1;
      expBusy = 1'b0;
    end
    checkOutput({tag, ".tx"}, txOut, expTx);
    checkOutput({tag, ".busy"}, busy, expBusy);
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic [7:0] d,
                               input logic v, input logic pe, input logic pt, input int n);
    rst       = r;
    pData     = d;
    dataValid = v;
    parEn     = pe;
    parTyp    = pt;
    for (int i = 0; i < n; i++) stepCycle(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    pData       = 8'h00;
    dataValid   = 1'b0;
    parEn       = 1'b0;
    parTyp      = 1'b0;

    $display("[TB] reset");
    applyStimulus("reset", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3);
    applyStimulus("idle", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2);

    $display("[TB] single frame 0xA5");
    applyStimulus("a5", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus("a5", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 12);

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity frames 0x07");
    applyStimulus("parEven", 1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1);
    applyStimulus("parEven", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 13);
    applyStimulus("parOdd", 1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1);
    applyStimulus("parOdd", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 13);
`endif

    $display("[TB] back-to-back 0x55 then 0x0F");
    applyStimulus("b2b", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus("b2b", 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 10);
    applyStimulus("b2b", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 14);

    $display("[TB] ignored request during DATA");
    applyStimulus("ignore", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus("ignore", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3);
    applyStimulus("ignore", 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1);
    applyStimulus("ignore", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 12);

    $display("[TB] reset mid-frame then 0x3C");
    applyStimulus("abort", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus("abort", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4);
    applyStimulus("abortRst", 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus("abortRst", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2);
    applyStimulus("post3c", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus("post3c", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 12);

    $display("[TB] live input churn during 0x81");
    applyStimulus("churn", 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus("churn", 1'b1, 8'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1);
    end
    applyStimulus("churn", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2);

    if (expQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d queued bits expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
